reg_write_arbiter: RTL and testbench

//   Shares the single write port of reg_file between two writeback sources:
//   REQ0 = pipeline WB stage, REQ1 = multi-cycle unit (mul/div, late load).

---
 rtl/reg_write_arbiter_if.sv | 48 ++++
 rtl/reg_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Purpose  : Bundles the two writeback request channels, the register-file
//            write port, the hazard query and the busy flag of
//            reg_write_arbiter into one interface.
// Modports : master - request issuer / reg_file side (drives REQn_*, QUERY_ADDRESS)
//            slave  - the arbiter itself (drives READY, WRITE_*, QUERY_HIT, BUSY)
// Revision : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  REQ0_VALID;
  logic                  REQ0_READY;
  logic [ADDR_WIDTH-1:0] REQ0_ADDRESS;
  logic [DATA_WIDTH-1:0] REQ0_DATA;
  logic                  REQ1_VALID;
  logic                  REQ1_READY;
  logic [ADDR_WIDTH-1:0] REQ1_ADDRESS;
  logic [DATA_WIDTH-1:0] REQ1_DATA;
  logic                  WRITE_ENABLE;
  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS;
  logic [DATA_WIDTH-1:0] WRITE_DATA;
  logic [ADDR_WIDTH-1:0] QUERY_ADDRESS;
  logic                  QUERY_HIT;
  logic                  BUSY;

  modport master (
    output REQ0_VALID, REQ0_ADDRESS, REQ0_DATA,
    output REQ1_VALID, REQ1_ADDRESS, REQ1_DATA,
    output QUERY_ADDRESS,
    input  REQ0_READY, REQ1_READY,
    input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
    input  QUERY_HIT, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_ADDRESS, REQ0_DATA,
    input  REQ1_VALID, REQ1_ADDRESS, REQ1_DATA,
    input  QUERY_ADDRESS,
    output REQ0_READY, REQ1_READY,
    output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
    output QUERY_HIT, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Shares the single reg_file write port between two writeback
//            sources (0 = pipeline WB, 1 = multi-cycle unit). Each source has
//            a FIFO_DEPTH-entry queue; one queued write issues per cycle.
//            QUERY_HIT flags pending writes so decode can stall on RAW.
// Ports    : CLK, RESET (sync, active-high)
//            bus (reg_write_arbiter_if.slave): REQn_VALID/READY/ADDRESS/DATA,
//            WRITE_ENABLE/ADDRESS/DATA, QUERY_ADDRESS/HIT, BUSY
// Options  : define ROUND_ROBIN_EN for alternating grant on contention;
//            default build is strict REQ0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  reg_write_arbiter_if.slave bus
);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Queue state, indexed [requester]
  logic [C_CNT_W-1:0]    cnt_q      [2];
  logic [C_CNT_W-1:0]    cnt_d      [2];
  logic [C_PTR_W-1:0]    rd_ptr_q   [2];
  logic [C_PTR_W-1:0]    rd_ptr_d   [2];
  logic [C_PTR_W-1:0]    wr_ptr_q   [2];
  logic [C_PTR_W-1:0]    wr_ptr_d   [2];
  logic [ADDR_WIDTH-1:0] addr_mem_q [2][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [2][FIFO_DEPTH];

  logic [1:0]            w_req_valid;
  logic [ADDR_WIDTH-1:0] w_req_addr [2];
  logic [DATA_WIDTH-1:0] w_req_data [2];
  logic [1:0]            w_ready;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_not_empty;
  logic                  w_grant1;
  logic                  w_write_en;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_query_hit;

  assign w_req_valid[0] = bus.REQ0_VALID;
  assign w_req_valid[1] = bus.REQ1_VALID;
  assign w_req_addr[0]  = bus.REQ0_ADDRESS;
  assign w_req_addr[1]  = bus.REQ1_ADDRESS;
  assign w_req_data[0]  = bus.REQ0_DATA;
  assign w_req_data[1]  = bus.REQ1_DATA;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_not_empty[i] = (cnt_q[i] != '0);
      // Count before the edge: a full queue is not ready even while popping.
      w_ready[i]     = !RESET && (cnt_q[i] < C_CNT_W'(FIFO_DEPTH));
      // Writes to x0 complete the handshake but are dropped here.
      w_push[i]      = w_req_valid[i] && w_ready[i] && (w_req_addr[i] != '0);
    end
  end

`ifdef ROUND_ROBIN_EN
  // rr_last_q = requester granted on the most recent contended cycle.
  logic rr_last_q;
  logic rr_last_d;
  logic w_contended;

  assign w_contended = &w_not_empty;
  assign w_grant1    = w_not_empty[1] && (!w_not_empty[0] || !rr_last_q);

  always_comb begin
    rr_last_d = rr_last_q;
    if (w_write_en && w_contended) begin
      rr_last_d = w_grant1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  assign w_grant1 = w_not_empty[1] && !w_not_empty[0];
`endif

  assign w_write_en = !RESET && (|w_not_empty);
  assign w_pop[0]   = w_write_en && !w_grant1;
  assign w_pop[1]   = w_write_en && w_grant1;

  assign w_head_addr = w_grant1 ? addr_mem_q[1][rd_ptr_q[1]] : addr_mem_q[0][rd_ptr_q[0]];
  assign w_head_data = w_grant1 ? data_mem_q[1][rd_ptr_q[1]] : data_mem_q[0][rd_ptr_q[0]];

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = cnt_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (w_push[i]) begin
        addr_mem_d[i][wr_ptr_q[i]] = w_req_addr[i];
        data_mem_d[i][wr_ptr_q[i]] = w_req_data[i];
        wr_ptr_d[i]                = wr_ptr_q[i] + C_PTR_W'(1);
      end
      if (w_pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + C_PTR_W'(1);
      end
      if (w_push[i] && !w_pop[i]) begin
        cnt_d[i] = cnt_q[i] + C_CNT_W'(1);
      end else if (w_pop[i] && !w_push[i]) begin
        cnt_d[i] = cnt_q[i] - C_CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible through the counts.
  always_ff @(posedge CLK) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Scan the occupied slots only (rd_ptr + j for j < count); stale slots
  // left behind by pops must not raise a hazard.
  always_comb begin
    w_query_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if ((C_CNT_W'(j) < cnt_q[i]) &&
            (addr_mem_q[i][C_PTR_W'(rd_ptr_q[i] + C_PTR_W'(j))] == bus.QUERY_ADDRESS)) begin
          w_query_hit = 1'b1;
        end
      end
    end
    if (bus.QUERY_ADDRESS == '0) begin
      w_query_hit = 1'b0;
    end
  end

  assign bus.REQ0_READY    = w_ready[0];
  assign bus.REQ1_READY    = w_ready[1];
  assign bus.WRITE_ENABLE  = w_write_en;
  assign bus.WRITE_ADDRESS = w_write_en ? w_head_addr : '0;
  assign bus.WRITE_DATA    = w_write_en ? w_head_data : '0;
  assign bus.QUERY_HIT     = w_query_hit;
  assign bus.BUSY          = |w_not_empty;
endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Directed self-checking bench for reg_write_arbiter: reset,
//            single write, contention, backpressure, x0 drop, hazard query
//            and reset mid-operation. A small reg_file model and write log
//            record everything issued on the write port.
// Options  : expectations follow ROUND_ROBIN_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int total  = 0;
  int passes = 0;

  logic [DW-1:0] rf [32];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];

  always @(posedge clk) begin
    if (bus.WRITE_ENABLE) begin
      rf[bus.WRITE_ADDRESS] <= bus.WRITE_DATA;
      log_addr.push_back(bus.WRITE_ADDRESS);
      log_data.push_back(bus.WRITE_DATA);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.REQ0_VALID = 1'b0; bus.REQ0_ADDRESS = '0; bus.REQ0_DATA = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_ADDRESS = '0; bus.REQ1_DATA = '0;
  endtask

  task automatic req0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.REQ0_VALID = 1'b1; bus.REQ0_ADDRESS = a; bus.REQ0_DATA = d;
  endtask

  task automatic req1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.REQ1_VALID = 1'b1; bus.REQ1_ADDRESS = a; bus.REQ1_DATA = d;
  endtask

  initial begin
    int n;
    int start;
    int hits;
    logic [AW-1:0] seen_a [$];
    logic [DW-1:0] seen_d [$];

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    idle();
    bus.QUERY_ADDRESS = '0;

    // ---- reset held two cycles
    tick();
    chk("rst_we", bus.WRITE_ENABLE, 0);
    chk("rst_ready0", bus.REQ0_READY, 0);
    chk("rst_ready1", bus.REQ1_READY, 0);
    tick();
    chk("rst2_we", bus.WRITE_ENABLE, 0);
    chk("rst2_ready0", bus.REQ0_READY, 0);

    // ---- single write from REQ0
    rst = 1'b0;
    req0(5'd1, 32'd10);
    #1;
    chk("post_rst_ready0", bus.REQ0_READY, 1);
    chk("post_rst_ready1", bus.REQ1_READY, 1);
    chk("post_rst_busy", bus.BUSY, 0);
    chk("no_bypass_we", bus.WRITE_ENABLE, 0);
    chk("idle_wdata", bus.WRITE_DATA, 0);
    tick();
    idle();
    #1;
    chk("single_we", bus.WRITE_ENABLE, 1);
    chk("single_wa", bus.WRITE_ADDRESS, 1);
    chk("single_wd", bus.WRITE_DATA, 10);
    chk("single_busy", bus.BUSY, 1);
    tick();
    chk("single_done_we", bus.WRITE_ENABLE, 0);
    chk("single_done_wa", bus.WRITE_ADDRESS, 0);
    chk("single_done_busy", bus.BUSY, 0);
    chk("rf_addr1", rf[1], 10);

    // ---- contention, first pair
    req0(5'd3, 32'h33);
    req1(5'd4, 32'h44);
    tick();
    idle();
    #1;
    chk("cont1_wa_first", bus.WRITE_ADDRESS, 3);
    chk("cont1_wd_first", bus.WRITE_DATA, 32'h33);
    tick();
    chk("cont1_we_second", bus.WRITE_ENABLE, 1);
    chk("cont1_wa_second", bus.WRITE_ADDRESS, 4);
    chk("cont1_wd_second", bus.WRITE_DATA, 32'h44);
    tick();
    chk("cont1_idle_we", bus.WRITE_ENABLE, 0);

    // ---- contention, second pair
    req0(5'd3, 32'h35);
    req1(5'd4, 32'h46);
    tick();
    idle();
    #1;
`ifdef ROUND_ROBIN_EN
    chk("cont2_wa_first", bus.WRITE_ADDRESS, 4);
    chk("cont2_wd_first", bus.WRITE_DATA, 32'h46);
    tick();
    chk("cont2_wa_second", bus.WRITE_ADDRESS, 3);
`else
    chk("cont2_wa_first", bus.WRITE_ADDRESS, 3);
    chk("cont2_wd_first", bus.WRITE_DATA, 32'h35);
    tick();
    chk("cont2_wa_second", bus.WRITE_ADDRESS, 4);
`endif
    tick();
    chk("cont2_busy", bus.BUSY, 0);
    chk("rf_addr3", rf[3], 32'h35);
    chk("rf_addr4", rf[4], 32'h46);

    // ---- backpressure on REQ1 while REQ0 keeps its queue busy
    start = log_addr.size();
    req0(5'd20, 32'hA0);
    req1(5'd5, 32'h55);
    #1;
    chk("bp_ready1_a", bus.REQ1_READY, 1);
    tick();
    req0(5'd21, 32'hA1);
    req1(5'd6, 32'h56);
    #1;
    chk("bp_ready1_b", bus.REQ1_READY, 1);
    tick();
    req0(5'd22, 32'hA2);
    req1(5'd7, 32'h57);
    #1;
    chk("bp_full_ready1", bus.REQ1_READY, 0);
    chk("bp_ready0", bus.REQ0_READY, 1);
    tick();
    bus.REQ0_VALID = 1'b0;
    #1;
    n = 0;
    while (!bus.REQ1_READY && n < 20) begin
      tick();
      n++;
    end
    chk("bp_ready1_frees", bus.REQ1_READY, 1);
    tick();
    idle();
    #1;
    n = 0;
    while (bus.BUSY && n < 20) begin
      tick();
      n++;
    end
    chk("bp_drained", bus.BUSY, 0);
    for (int k = start; k < log_addr.size(); k++) begin
      if (log_addr[k] >= 5'd5 && log_addr[k] <= 5'd7) begin
        seen_a.push_back(log_addr[k]);
        seen_d.push_back(log_data[k]);
      end
    end
    chk("bp_req1_writes", seen_a.size(), 3);
    for (int k = 0; k < seen_a.size() && k < 3; k++) begin
      chk("bp_order_addr", seen_a[k], 5 + k);
      chk("bp_order_data", seen_d[k], 32'h55 + k);
    end

    // ---- write to x0 is dropped
    req0(5'd0, 32'hFF);
    #1;
    chk("x0_ready0", bus.REQ0_READY, 1);
    tick();
    idle();
    #1;
    chk("x0_we", bus.WRITE_ENABLE, 0);
    chk("x0_busy", bus.BUSY, 0);

    // ---- hazard query on a queued write
    req0(5'd9, 32'h99);
    bus.QUERY_ADDRESS = 5'd9;
    #1;
    chk("hit_arrival", bus.QUERY_HIT, 0);
    tick();
    idle();
    #1;
    chk("hit_pending", bus.QUERY_HIT, 1);
    chk("hit_wa", bus.WRITE_ADDRESS, 9);
    bus.QUERY_ADDRESS = 5'd0;
    #1;
    chk("hit_x0", bus.QUERY_HIT, 0);
    bus.QUERY_ADDRESS = 5'd9;
    tick();
    chk("hit_after_pop", bus.QUERY_HIT, 0);
    chk("hit_after_pop_we", bus.WRITE_ENABLE, 0);
    bus.QUERY_ADDRESS = 5'd0;

    // ---- reset mid-operation discards pending writes
    req0(5'd12, 32'hC);
    req1(5'd13, 32'hD);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_we", bus.WRITE_ENABLE, 0);
    chk("midrst_ready0", bus.REQ0_READY, 0);
    chk("midrst_busy_pre", bus.BUSY, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_we_after", bus.WRITE_ENABLE, 0);
    chk("midrst_ready0_after", bus.REQ0_READY, 1);
    tick();
    tick();
    tick();
    hits = 0;
    foreach (log_addr[k]) begin
      if (log_addr[k] == 5'd12 || log_addr[k] == 5'd13) hits++;
    end
    chk("midrst_no_discarded_write", hits, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
`default_nettype wire
